// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM.
// The ALUOp encodings are shared with the downstream ALU control decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic       instrDone;
  } ctrl_t;

  function automatic logic isLegalOp(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure state-to-control decode for the multicycle MIPS control FSM.
// Handshake qualification and reset masking are applied by the parent.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // FETCH/MEMWRITE enables here are unconditional; the top qualifies them with mem_ready.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        ctrl_o.irWrite  = 1'b1;
        ctrl_o.pcWrite  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB = SRCB_IMMSH;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDIEXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.memToReg  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.iorD      = 1'b1;
        ctrl_o.memWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_REG;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.regDst    = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_REG;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
        ctrl_o.instrDone   = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.instrDone = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state
// logic, memory-ready stalling and reset masking of all write enables.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  dec;
  logic   memWait;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_RTYPEWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (dec)
  );

  // A pending memory access holds back every enable that would commit the access.
  assign memWait = !mem_ready &&
                   (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE);

  assign pc_write      = rst_n & dec.pcWrite & ~memWait;
  assign pc_write_cond = rst_n & dec.pcWriteCond;
  assign ir_write      = rst_n & dec.irWrite & ~memWait;
  assign reg_write     = rst_n & dec.regWrite;
  assign mem_write     = rst_n & dec.memWrite;
  assign instr_done    = rst_n & dec.instrDone & ~memWait;
  assign illegal_op    = rst_n & (state_q == S_DECODE) & ~isLegalOp(opcode);

  assign ior_d      = dec.iorD;
  assign mem_read   = dec.memRead;
  assign mem_to_reg = dec.memToReg;
  assign reg_dst    = dec.regDst;
  assign alu_src_a  = dec.aluSrcA;
  assign pc_source  = dec.pcSource;
  assign alu_op     = dec.aluOp;
  assign alu_src_b  = dec.aluSrcB;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for the multicycle MIPS control FSM: instructions are described as
// phase lists with their wait states and compared cycle by cycle.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_write, reg_dst, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ior_d         (ior_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .alu_src_b     (alu_src_b),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pcW, pcWC, iorD, mRd, mWr, m2r, irW, rW, rDst, aSrcA;
    logic [1:0] pcSrc, aluOp, aSrcB;
    logic       done, ill;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic       rdy;
    logic       rstN;
    logic [5:0] op;
  } cyc_t;

  cyc_t plan[$];
  vec_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycNo = 0;
  int   expDone = 0;
  int   seenDone = 0;

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic vec_t blank(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic vec_t fetchVec(input logic rdy, input logic inReset);
    vec_t v;
    v = blank(4'd0);
    v.mRd = 1'b1;
    v.aSrcB = 2'b01;
    if (rdy && !inReset) begin
      v.irW = 1'b1;
      v.pcW = 1'b1;
    end
    return v;
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic pushCycle(input vec_t v, input logic rdy, input logic [5:0] op, input logic rstN);
    cyc_t c;
    c.v = v;
    c.rdy = rdy;
    c.op = op;
    c.rstN = rstN;
    plan.push_back(c);
    if (v.done) expDone++;
  endtask

  task automatic planFetch(input int fWait);
    for (int i = 0; i < fWait; i++) pushCycle(fetchVec(1'b0, 1'b0), 1'b0, 6'($urandom), 1'b1);
    pushCycle(fetchVec(1'b1, 1'b0), 1'b1, 6'($urandom), 1'b1);
  endtask

  task automatic planDecode(input logic [5:0] op);
    vec_t v;
    v = blank(4'd1);
    v.aSrcB = 2'b11;
    v.ill = !legal(op);
    pushCycle(v, rndBit(), op, 1'b1);
  endtask

  task automatic planAddrCalc(input logic [3:0] st, input logic [5:0] op);
    vec_t v;
    v = blank(st);
    v.aSrcA = 1'b1;
    v.aSrcB = 2'b10;
    pushCycle(v, rndBit(), op, 1'b1);
  endtask

  task automatic planInstr(input logic [5:0] op, input int fWait, input int mWait);
    vec_t v;
    planFetch(fWait);
    planDecode(op);
    case (op)
      6'b100011: begin
        planAddrCalc(4'd2, op);
        v = blank(4'd3);
        v.mRd = 1'b1;
        v.iorD = 1'b1;
        for (int i = 0; i < mWait; i++) pushCycle(v, 1'b0, op, 1'b1);
        pushCycle(v, 1'b1, op, 1'b1);
        v = blank(4'd4);
        v.rW = 1'b1;
        v.m2r = 1'b1;
        v.done = 1'b1;
        pushCycle(v, rndBit(), op, 1'b1);
      end
      6'b101011: begin
        planAddrCalc(4'd2, op);
        v = blank(4'd5);
        v.iorD = 1'b1;
        v.mWr = 1'b1;
        for (int i = 0; i < mWait; i++) pushCycle(v, 1'b0, op, 1'b1);
        v.done = 1'b1;
        pushCycle(v, 1'b1, op, 1'b1);
      end
      6'b000000: begin
        v = blank(4'd6);
        v.aSrcA = 1'b1;
        v.aluOp = 2'b10;
        pushCycle(v, rndBit(), op, 1'b1);
        v = blank(4'd7);
        v.rW = 1'b1;
        v.rDst = 1'b1;
        v.done = 1'b1;
        pushCycle(v, rndBit(), op, 1'b1);
      end
      6'b000100: begin
        v = blank(4'd8);
        v.aSrcA = 1'b1;
        v.aluOp = 2'b01;
        v.pcWC = 1'b1;
        v.pcSrc = 2'b01;
        v.done = 1'b1;
        pushCycle(v, rndBit(), op, 1'b1);
      end
      6'b000010: begin
        v = blank(4'd9);
        v.pcW = 1'b1;
        v.pcSrc = 2'b10;
        v.done = 1'b1;
        pushCycle(v, rndBit(), op, 1'b1);
      end
      6'b001000: begin
        planAddrCalc(4'd10, op);
        v = blank(4'd11);
        v.rW = 1'b1;
        v.done = 1'b1;
        pushCycle(v, rndBit(), op, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic planReset(input int n);
    for (int i = 0; i < n; i++) pushCycle(fetchVec(1'b1, 1'b1), 1'b1, 6'($urandom), 1'b0);
  endtask

  // lw interrupted by reset while its read is outstanding
  task automatic planAbortedLw();
    vec_t v;
    planFetch(0);
    planDecode(OP_LW);
    planAddrCalc(4'd2, OP_LW);
    v = blank(4'd3);
    v.mRd = 1'b1;
    v.iorD = 1'b1;
    pushCycle(v, 1'b0, OP_LW, 1'b1);
    planReset(2);
  endtask

  function automatic logic [5:0] randomOp();
    logic [5:0] r;
    case ($urandom_range(0, 6))
      0: r = 6'b100011;
      1: r = 6'b101011;
      2: r = 6'b000000;
      3: r = 6'b000100;
      4: r = 6'b000010;
      5: r = 6'b001000;
      default: begin
        r = 6'($urandom);
        while (legal(r)) r = 6'($urandom);
      end
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input cyc_t c);
    rst_n = c.rstN;
    mem_ready = c.rdy;
    opcode = c.op;
    expQ.push_back(c.v);
  endtask

  task automatic checkOutput(input vec_t expV);
    vec_t act;
    act = {state, pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, pc_source, alu_op, alu_src_b,
           instr_done, illegal_op};
    checks++;
    if (act !== expV) begin
      errors++;
      $display("[TB] FAIL cycle%0d outputs: got=%h want=%h (got state %0d, want state %0d)",
               cycNo, act, expV, act.st, expV.st);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        cycNo++;
        if (instr_done) seenDone++;
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    planReset(3);
    planInstr(OP_LW, 0, 0);
    planInstr(OP_SW, 0, 2);
    planInstr(OP_RTYPE, 1, 0);
    planInstr(OP_BEQ, 0, 0);
    planInstr(6'b111111, 0, 0);
    planInstr(OP_J, 2, 0);
    planInstr(OP_ADDI, 0, 0);
    planInstr(OP_LW, 1, 3);
    planAbortedLw();
    for (int n = 0; n < 150; n++) begin
      planInstr(randomOp(), $urandom_range(0, 2), $urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) planReset(1);
    end

    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    while (plan.size() > 0) begin
      @(posedge clk);
      #1;
      applyStimulus(plan.pop_front());
    end
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d unchecked cycles, want 0", expQ.size());
    end
    checks++;
    if (seenDone != expDone) begin
      errors++;
      $display("[TB] FAIL doneCount: got %0d instr_done pulses, want %0d", seenDone, expDone);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
